ex_mdu: RTL and testbench
=========================

// Module: ex_mdu
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage (RV32M: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  EX launches an op, holds the pipeline via stall_o, then forwards result_o/wd_o to EX/MEM on the done_o pulse.
//  Radix-2^BPC shift-add multiply and restoring divide; special divide cases short-circuit.
// PARAMETERS
//  XLEN  32  operand/result width
//  BPC   1   bits retired per CALC cycle; must divide XLEN evenly (1,2,4,8)
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     asynchronous reset, active-high
//  start_i   in   1     launch op; sampled only in IDLE
//  op_i      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1_i     in   XLEN  operand 1 (dividend / multiplicand)
//  rs2_i     in   XLEN  operand 2 (divisor / multiplier)
//  wd_i      in   5     destination register address
//  flush_i   in   1     abort the in-flight op (branch/exception flush)
//  busy_o    out  1     1 while state != IDLE
//  stall_o   out  1     start_i | (state==CALC); request EX stall
//  done_o    out  1     single-cycle pulse: result_o/wd_o valid
//  result_o  out  XLEN  result; held stable until the next accepted start
//  wd_o      out  5     latched wd_i for the op
// BEHAVIOUR
//  Reset: state=IDLE; busy_o=0, done_o=0, result_o=0, wd_o=0, all internal registers 0.
//  FSM: IDLE -> CALC on start_i & ~flush_i (latch op, wd, operand magnitudes, result signs, count=XLEN/BPC).
//       IDLE -> DONE directly for special divide cases (below); CALC stays while count!=0, count -= 1 per cycle.
//       CALC -> DONE when count reaches 0; DONE -> IDLE unconditionally; done_o=1 only in DONE.
//  Latency: start accepted at edge N -> done_o high in cycle N+XLEN/BPC+1 (33 cycles for XLEN=32,BPC=1).
//           Special cases: done_o in cycle N+1.
//  Signedness: MULH signed x signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned.
//    Operate on magnitudes; negate the 2*XLEN product / quotient / remainder at DONE entry per latched signs.
//  MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
//  Divide sign rules: quotient negative iff signs differ; remainder takes dividend sign.
//  Special cases (no CALC):
//    divisor==0: quotient = all ones; remainder = rs1_i (signed and unsigned).
//    DIV/REM with rs1=-2^(XLEN-1), rs2=-1: quotient = -2^(XLEN-1); remainder = 0.
//  start_i while busy_o=1: ignored, no effect on the running op.
//  flush_i: any state -> IDLE next edge; done_o suppressed; result_o/wd_o keep old values.
//    flush_i and start_i both high in IDLE: flush wins, op not accepted.
//  Back-to-back: start_i in the cycle after DONE (state IDLE) is accepted normally.
//  rst asserted mid-op: immediate return to reset values, no done_o pulse.
//  rs1/rs2 need not be held after acceptance (latched).
// TESTING
//  MUL 7 x -3 (BPC=1) -> done_o at start+33; result_o=32'hFFFF_FFEB; wd_o = latched wd_i.
//  MULH 32'h8000_0000 x 32'h8000_0000 -> 32'h4000_0000; MULHU 32'hFFFF_FFFF x 2 -> 1; MULHSU -1 x 2 -> 32'hFFFF_FFFF.
//  DIV -7 / 2 -> -3 (32'hFFFF_FFFD); REM -7 / 2 -> -1; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
//  DIV x/0 with x=5 -> result 32'hFFFF_FFFF at start+1; REM 5/0 -> 5; DIV 32'h8000_0000 / -1 -> 32'h8000_0000, REM -> 0.
//  flush_i at CALC cycle 10 -> IDLE next edge, no done_o; following MULHU 3x3 -> 0 completes normally.
//  Re-run MUL and DIV vectors with BPC=4 -> identical results, done_o at start+9; start_i while busy_o ignored.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M multiply/divide unit for the EX stage.
// Radix-2^BPC shift-add multiply and restoring divide operate on operand
// magnitudes. Signs are applied once, when the result is latched on DONE entry.
// Divide-by-zero and signed overflow bypass the iteration.
module ex_mdu #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      wd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wd_o
);

  localparam int CNT = XLEN / BPC;
  localparam int CW  = $clog2(CNT + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_nxt;
  logic [2:0]          op_q;
  logic [4:0]          wd_q;
  logic                neg_q;      // product / quotient must be negated
  logic                negr_q;     // remainder must be negated (dividend sign)
  logic [XLEN-1:0]     b_q;        // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0]   acc_q;      // {hi, lo}: product/multiplier or remainder/quotient
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     res_q;      // result captured on DONE entry
  logic [XLEN-1:0]     res_out_q;  // last result actually delivered
  logic [4:0]          wd_out_q;

  logic                accept;
  logic                is_div;
  logic                sgn_a, sgn_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;
  logic [2*XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]     fin_res;

  // Two's complement negation helpers for single and double width values.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  // Launch decode: operand signs, magnitudes and the divide short-circuits.
  always_comb begin
    accept      = (state_q == IDLE) && start_i && !flush_i;
    is_div      = op_i[2];
    sgn_a       = rs1_i[XLEN-1] &&
                  (op_i == 3'd1 || op_i == 3'd2 || op_i == 3'd4 || op_i == 3'd6);
    sgn_b       = rs2_i[XLEN-1] &&
                  (op_i == 3'd1 || op_i == 3'd4 || op_i == 3'd6);
    mag_a       = sgn_a ? neg_x(rs1_i) : rs1_i;
    mag_b       = sgn_b ? neg_x(rs2_i) : rs2_i;
    div_zero    = is_div && (rs2_i == '0);
    div_ovf     = is_div && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = op_i[1] ? rs1_i : '1;
    else
      special_res = op_i[1] ? '0 : rs1_i;
  end

  // One CALC iteration: BPC multiplier digits retired, or BPC quotient bits.
  always_comb begin
    logic [XLEN+BPC-1:0] sum;
    logic [XLEN:0]       r;
    logic [XLEN-1:0]     q;
    sum = {{BPC{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
          ({{BPC{1'b0}}, b_q} * {{XLEN{1'b0}}, acc_q[BPC-1:0]});
    r   = {1'b0, acc_q[2*XLEN-1:XLEN]};
    q   = acc_q[XLEN-1:0];
    for (int i = 0; i < BPC; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, b_q}) begin
        r    = r - {1'b0, b_q};
        q[0] = 1'b1;
      end
    end
    if (op_q[2])
      acc_nxt = {r[XLEN-1:0], q};
    else
      acc_nxt = {sum, acc_q[XLEN-1:BPC]};
  end

  // Final result selection with sign correction from the last iteration.
  always_comb begin
    logic [2*XLEN-1:0] prod;
    prod    = neg_q ? neg_2x(acc_nxt) : acc_nxt;
    fin_res = '0;
    if (!op_q[2])
      fin_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])
      fin_res = negr_q ? neg_x(acc_nxt[2*XLEN-1:XLEN]) : acc_nxt[2*XLEN-1:XLEN];
    else
      fin_res = neg_q ? neg_x(acc_nxt[XLEN-1:0]) : acc_nxt[XLEN-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_nxt;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (flush_i)
          state_nxt = IDLE;
        else if (cnt_q == CW'(1))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; a flush in DONE suppresses the pulse.
  always_comb begin
    busy_o   = (state_q != IDLE);
    stall_o  = start_i || (state_q == CALC);
    done_o   = (state_q == DONE) && !flush_i;
    result_o = (state_q == DONE) ? res_q : res_out_q;
    wd_o     = (state_q == DONE) ? wd_q  : wd_out_q;
  end

  // Operand latching, iteration and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      wd_q      <= '0;
      neg_q     <= 1'b0;
      negr_q    <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_out_q <= '0;
      wd_out_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= op_i;
            wd_q   <= wd_i;
            neg_q  <= sgn_a ^ sgn_b;
            negr_q <= sgn_a;
            cnt_q  <= CW'(CNT);
            if (is_div) begin
              acc_q <= {{XLEN{1'b0}}, mag_a};
              b_q   <= mag_b;
            end else begin
              acc_q <= {{XLEN{1'b0}}, mag_b};
              b_q   <= mag_a;
            end
            if (special)
              res_q <= special_res;
          end
        end
        CALC: begin
          if (!flush_i) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1))
              res_q <= fin_res;
          end
        end
        DONE: begin
          if (!flush_i) begin
            res_out_q <= res_q;
            wd_out_q  <= wd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: two instances (BPC=1 and BPC=4) share one stimulus stream.
module tb_ex_mdu;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  wd_i;
  logic        flush_i;
  logic        busy1, stall1, done1, busy4, stall4, done4;
  logic [31:0] res1, res4;
  logic [4:0]  wd1, wd4;

  typedef struct {logic [31:0] res; logic [4:0] wd;} exp_t;
  exp_t q1[$];
  exp_t q4[$];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ex_mdu #(.XLEN(32), .BPC(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .wd_i(wd_i), .flush_i(flush_i), .busy_o(busy1),
    .stall_o(stall1), .done_o(done1), .result_o(res1), .wd_o(wd1));

  ex_mdu #(.XLEN(32), .BPC(4)) u4 (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .wd_i(wd_i), .flush_i(flush_i), .busy_o(busy4),
    .stall_o(stall4), .done_o(done4), .result_o(res4), .wd_o(wd4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    p  = '0;
    case (op)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Launch one op, watch both instances for 40 cycles, check results and timing.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic [31:0] exp, input bit busy_pulse);
    bit   sp;
    int   lat1, lat4, p1, p4;
    exp_t e;
    sp = op[2] && (b == 0 || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; wd_i = wd;
    e.res = exp; e.wd = wd;
    q1.push_back(e);
    q4.push_back(e);
    #1 chk("stall_on_start", {31'b0, stall1}, 32'd1);
    lat1 = 0; lat4 = 0; p1 = 0; p4 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 2) chk("stall_calc", {31'b0, stall1}, {31'b0, !sp});
      if (done1) begin
        p1++;
        if (p1 == 1 && q1.size() > 0) begin
          lat1 = n;
          e = q1.pop_front();
          chk("res_bpc1", res1, e.res);
          chk("wd_bpc1", {27'b0, wd1}, {27'b0, e.wd});
        end
      end
      if (done4) begin
        p4++;
        if (p4 == 1 && q4.size() > 0) begin
          lat4 = n;
          e = q4.pop_front();
          chk("res_bpc4", res4, e.res);
          chk("wd_bpc4", {27'b0, wd4}, {27'b0, e.wd});
        end
      end
      if (n == 1) begin
        start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; wd_i = ~wd;
      end
      if (busy_pulse && n == 3) begin start_i = 1'b1; op_i = 3'd3; end
      if (busy_pulse && n == 4) start_i = 1'b0;
    end
    chk("lat_bpc1", lat1, sp ? 32'd1 : 32'd33);
    chk("lat_bpc4", lat4, sp ? 32'd1 : 32'd9);
    chk("pulses_bpc1", p1, 32'd1);
    chk("pulses_bpc4", p4, 32'd1);
    chk("held_bpc1", res1, exp);
    chk("held_bpc4", res4, exp);
    q1.delete();
    q4.delete();
  endtask

  typedef struct {logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp;} vec_t;
  vec_t vt[$];

  initial begin
    int          nd;
    logic [31:0] prev;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; wd_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    chk("rst_done", {31'b0, done1}, 32'd0);
    chk("rst_res", res1, 32'd0);
    chk("rst_wd", {27'b0, wd1}, 32'd0);
    chk("rst_res4", res4, 32'd0);
    rst = 1'b0;

    vt.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vt.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    vt.push_back('{3'd3, 32'hFFFF_FFFF,  32'd2,         32'd1});
    vt.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
    vt.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vt.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vt.push_back('{3'd5, 32'd100,        32'd7,         32'd14});
    vt.push_back('{3'd7, 32'd100,        32'd7,         32'd2});
    vt.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF});
    vt.push_back('{3'd6, 32'd5,          32'd0,         32'd5});
    vt.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vt.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    vt.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF});
    vt.push_back('{3'd7, 32'd5,          32'd0,         32'd5});
    foreach (vt[i])
      run_op(vt[i].op, vt[i].a, vt[i].b, 5'(i + 1), vt[i].exp, i == 0);
    prev = 32'd5;

    // Flush in the middle of CALC: no pulse, outputs keep the previous result.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd1; rs1_i = 32'h1234_5678; rs2_i = 32'h9ABC_DEF0; wd_i = 5'd20;
    nd = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done1 || done4) nd++;
      if (n == 7) begin
        chk("flush_idle_bpc1", {31'b0, busy1}, 32'd0);
        chk("flush_idle_bpc4", {31'b0, busy4}, 32'd0);
      end
      if (n == 1) start_i = 1'b0;
      if (n == 6) flush_i = 1'b1;
      if (n == 7) flush_i = 1'b0;
    end
    chk("flush_no_done", nd, 32'd0);
    chk("flush_res_kept", res1, prev);
    chk("flush_wd_kept", {27'b0, wd1}, 32'd14);
    run_op(3'd3, 32'd3, 32'd3, 5'd21, 32'd0, 1'b0);

    // Flush and start together in IDLE: op not accepted.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; wd_i = 5'd22;
    @(negedge clk);
    chk("flush_start_bpc1", {31'b0, busy1}, 32'd0);
    chk("flush_start_bpc4", {31'b0, busy4}, 32'd0);
    start_i = 1'b0; flush_i = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 || done4) nd++;
    end
    chk("flush_start_no_done", nd, 32'd0);

    // Random operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(rop, ra, rb, 5'(i + 2), model(rop, ra, rb), 1'b0);
    end

    // Reset in the middle of an op.
    run_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0);
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd7; rs2_i = 32'd9; wd_i = 5'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy1", {31'b0, busy1}, 32'd0);
    chk("midrst_busy4", {31'b0, busy4}, 32'd0);
    chk("midrst_res1", res1, 32'd0);
    chk("midrst_wd1", {27'b0, wd1}, 32'd0);
    chk("midrst_res4", res4, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 || done4) nd++;
    end
    chk("midrst_no_done", nd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
